// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter: byte type and arbiter FSM states.
package uart_tx_arbiter_pkg;

  typedef logic [7:0] uart_byte_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus transmitter handshake shared by the arbiter and its users.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  import uart_tx_arbiter_pkg::*;

  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   in_req_valid;
  logic [8*N_REQ-1:0] in_req_data;
  logic [N_REQ-1:0]   in_req_last;
  logic [N_REQ-1:0]   out_req_ready;
  logic               in_tx_busy;
  uart_byte_t         out_tx_data;
  logic               out_tx_en;
  logic               out_grant_valid;
  logic [ID_W-1:0]    out_grant_id;
  logic               out_abort;

  modport slave (
    input  in_req_valid, in_req_data, in_req_last, in_tx_busy,
    output out_req_ready, out_tx_data, out_tx_en, out_grant_valid, out_grant_id, out_abort
  );

  modport master (
    output in_req_valid, in_req_data, in_req_last, in_tx_busy,
    input  out_req_ready, out_tx_data, out_tx_en, out_grant_valid, out_grant_id, out_abort
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first requester strictly after 'last', wrapping past N-1 to 0.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 any,
  output logic [$clog2(N)-1:0] idx
);

  localparam int W = $clog2(N);

  // Scan from the farthest candidate back to the nearest so the nearest one wins.
  always_comb begin
    logic [W-1:0] cand;
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = N; k >= 1; k--) begin
      cand = W'((int'(last) + k) % N);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte-stream requesters, one packet per grant,
// pacing bytes on the transmitter's busy falling edge and aborting stalled packets.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MAX_GAP = 1024
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int GAP_W = $clog2(MAX_GAP + 1);

  arb_state_e       state;
  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  last_grant;
  logic             grant_valid;
  logic             busy_old;
  logic [GAP_W-1:0] gap;
  uart_byte_t       byte_reg;
  logic             last_reg;
  logic             tx_en;
  logic             abort;
  logic             pick_any;
  logic [ID_W-1:0]  pick_idx;
  logic             fall;
  uart_byte_t       req_byte;

  rr_pick #(.N(N_REQ)) u_pick (
    .req  (bus.in_req_valid),
    .last (last_grant),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign fall     = busy_old & ~bus.in_tx_busy;
  assign req_byte = bus.in_req_data[{grant, 3'b000} +: 8];

  always_comb begin
    bus.out_req_ready = '0;
    if (state == LOAD) begin
      bus.out_req_ready[grant] = 1'b1;
    end
  end

  // byte_reg doubles as the transmitter data output; it is cleared whenever tx_en drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= ID_W'(N_REQ - 1);
      grant_valid <= 1'b0;
      busy_old    <= 1'b0;
      gap         <= '0;
      byte_reg    <= '0;
      last_reg    <= 1'b0;
      tx_en       <= 1'b0;
      abort       <= 1'b0;
    end else begin
      busy_old <= bus.in_tx_busy;
      abort    <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any && !bus.in_tx_busy) begin
            grant       <= pick_idx;
            grant_valid <= 1'b1;
            gap         <= '0;
            state       <= LOAD;
          end
        end
        LOAD: begin
          if (bus.in_req_valid[grant]) begin
            byte_reg <= req_byte;
            last_reg <= bus.in_req_last[grant];
            tx_en    <= 1'b1;
            gap      <= '0;
            state    <= SEND;
          end else if (gap == GAP_W'(MAX_GAP - 1)) begin
            abort       <= 1'b1;
            last_grant  <= grant;
            grant       <= '0;
            grant_valid <= 1'b0;
            gap         <= '0;
            state       <= IDLE;
          end else begin
            gap <= gap + 1'b1;
          end
        end
        SEND: begin
          if (bus.in_tx_busy) begin
            tx_en    <= 1'b0;
            byte_reg <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (fall) begin
            if (last_reg) begin
              last_grant  <= grant;
              grant       <= '0;
              grant_valid <= 1'b0;
              state       <= IDLE;
            end else begin
              gap   <= '0;
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_tx_en       = tx_en;
  assign bus.out_tx_data     = byte_reg;
  assign bus.out_grant_valid = grant_valid;
  assign bus.out_grant_id    = grant;
  assign bus.out_abort       = abort;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues, a 10-cycle busy
// transmitter model, and a monitor logging grants, transmitted bytes and abort pulses.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int N_REQ   = 4;
  localparam int MAX_GAP = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic txModelOn = 1'b1;
  logic manualBusy = 1'b0;
  logic modelBusy = 1'b0;
  int   modelCount = 0;

  beat_t reqQ[N_REQ][$];
  int    txLog[$];
  int    grantLog[$];
  logic [N_REQ-1:0] readySeen = '0;
  int    abortCount = 0;
  int    abortDelta = 0;
  int    lastFall = 0;
  int    cycleCount = 0;

  int compared = 0;
  int mismatched = 0;

  uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

  uart_tx_arbiter #(.N_REQ(N_REQ), .MAX_GAP(MAX_GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.in_tx_busy = txModelOn ? modelBusy : manualBusy;

  always #5 clk = ~clk;

  // Requester driver: drops a beat after its accepting edge, then presents the next one.
  initial begin
    logic [N_REQ-1:0]   acc;
    logic [N_REQ-1:0]   v;
    logic [8*N_REQ-1:0] d;
    logic [N_REQ-1:0]   l;
    bus.in_req_valid = '0;
    bus.in_req_data  = '0;
    bus.in_req_last  = '0;
    forever begin
      @(negedge clk);
      acc = rst_n ? (bus.out_req_ready & bus.in_req_valid) : '0;
      @(posedge clk);
      #1;
      v = '0;
      d = '0;
      l = '0;
      for (int i = 0; i < N_REQ; i++) begin
        if (acc[i] && reqQ[i].size() > 0) void'(reqQ[i].pop_front());
        if (reqQ[i].size() > 0) begin
          v[i]         = 1'b1;
          d[8*i +: 8]  = reqQ[i][0].data;
          l[i]         = reqQ[i][0].last;
        end
      end
      bus.in_req_valid = v;
      bus.in_req_data  = d;
      bus.in_req_last  = l;
    end
  end

  // Transmitter model: busy for 10 cycles per byte, logging each byte it starts.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!txModelOn) begin
        modelBusy  = 1'b0;
        modelCount = 0;
      end else if (modelCount > 0) begin
        modelCount--;
        if (modelCount == 0) modelBusy = 1'b0;
      end else if (bus.out_tx_en && !modelBusy) begin
        modelBusy  = 1'b1;
        modelCount = 10;
        txLog.push_back(int'(bus.out_tx_data));
      end
    end
  end

  initial begin
    logic prevGv;
    logic prevBusy;
    prevGv   = 1'b0;
    prevBusy = 1'b0;
    forever begin
      @(negedge clk);
      cycleCount++;
      if (bus.out_grant_valid && !prevGv) grantLog.push_back(int'(bus.out_grant_id));
      prevGv = bus.out_grant_valid;
      if (prevBusy && !bus.in_tx_busy) lastFall = cycleCount;
      prevBusy = bus.in_tx_busy;
      if (bus.out_abort) begin
        abortCount++;
        abortDelta = cycleCount - lastFall;
      end
      readySeen |= bus.out_req_ready;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int req, input logic [7:0] data, input logic last);
    beat_t b;
    b.data = data;
    b.last = last;
    reqQ[req].push_back(b);
  endtask

  task automatic clearLogs();
    txLog.delete();
    grantLog.delete();
    readySeen  = '0;
    abortCount = 0;
    abortDelta = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic bit queuesEmpty();
    for (int i = 0; i < N_REQ; i++) begin
      if (reqQ[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic waitDone(input int nGrants, input int budget, input string tag);
    int n;
    n = 0;
    while (n < budget && !(grantLog.size() >= nGrants && !bus.out_grant_valid && queuesEmpty())) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput({tag, "_done"}, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int n;
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("rst_grant_valid", 32'(bus.out_grant_valid), 32'd0);
    checkOutput("rst_tx_en", 32'(bus.out_tx_en), 32'd0);
    checkOutput("rst_tx_data", 32'(bus.out_tx_data), 32'd0);
    checkOutput("rst_grant_id", 32'(bus.out_grant_id), 32'd0);
    checkOutput("rst_abort", 32'(bus.out_abort), 32'd0);
    checkOutput("rst_ready", 32'(bus.out_req_ready), 32'd0);
    rst_n = 1'b1;

    $display("[TB] two-byte packet from req0");
    clearLogs();
    applyStimulus(0, 8'h48, 1'b0);
    applyStimulus(0, 8'h69, 1'b1);
    waitDone(1, 200, "t1");
    checkOutput("t1_grant0", 32'(grantLog[0]), 32'd0);
    checkOutput("t1_ngrant", 32'(grantLog.size()), 32'd1);
    checkOutput("t1_nbytes", 32'(txLog.size()), 32'd2);
    checkOutput("t1_byte0", 32'(txLog[0]), 32'h48);
    checkOutput("t1_byte1", 32'(txLog[1]), 32'h69);
    checkOutput("t1_idle_data", 32'(bus.out_tx_data), 32'd0);

    $display("[TB] req1 and req3 contend from reset");
    doReset();
    clearLogs();
    applyStimulus(1, 8'h11, 1'b0);
    applyStimulus(1, 8'h12, 1'b1);
    applyStimulus(3, 8'h31, 1'b1);
    applyStimulus(1, 8'h13, 1'b1);
    waitDone(3, 400, "t2");
    checkOutput("t2_grant0", 32'(grantLog[0]), 32'd1);
    checkOutput("t2_grant1", 32'(grantLog[1]), 32'd3);
    checkOutput("t2_grant2", 32'(grantLog[2]), 32'd1);
    checkOutput("t2_nbytes", 32'(txLog.size()), 32'd4);
    checkOutput("t2_byte1", 32'(txLog[1]), 32'h12);
    checkOutput("t2_byte2", 32'(txLog[2]), 32'h31);
    checkOutput("t2_byte3", 32'(txLog[3]), 32'h13);

    $display("[TB] single-byte packet from req2");
    clearLogs();
    applyStimulus(2, 8'hA5, 1'b1);
    waitDone(1, 200, "t3");
    checkOutput("t3_grant0", 32'(grantLog[0]), 32'd2);
    checkOutput("t3_nbytes", 32'(txLog.size()), 32'd1);
    checkOutput("t3_byte0", 32'(txLog[0]), 32'hA5);
    checkOutput("t3_ready_bits", 32'(readySeen), 32'b0100);

    $display("[TB] gap timeout on req0 with req1 waiting");
    clearLogs();
    applyStimulus(0, 8'h01, 1'b0);
    applyStimulus(1, 8'h22, 1'b1);
    waitDone(2, 400, "t4");
    checkOutput("t4_abort_count", 32'(abortCount), 32'd1);
    checkOutput("t4_abort_delay", 32'(abortDelta), 32'(MAX_GAP + 1));
    checkOutput("t4_grant0", 32'(grantLog[0]), 32'd0);
    checkOutput("t4_grant1", 32'(grantLog[1]), 32'd1);
    checkOutput("t4_nbytes", 32'(txLog.size()), 32'd2);
    checkOutput("t4_byte1", 32'(txLog[1]), 32'h22);

    $display("[TB] busy held through reset release");
    @(negedge clk);
    txModelOn  = 1'b0;
    manualBusy = 1'b1;
    rst_n      = 1'b0;
    clearLogs();
    applyStimulus(0, 8'h5A, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("t5_no_grant", 32'(bus.out_grant_valid), 32'd0);
    txModelOn  = 1'b1;
    manualBusy = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("t5_grant_valid", 32'(bus.out_grant_valid), 32'd1);
    checkOutput("t5_grant_id", 32'(bus.out_grant_id), 32'd0);
    waitDone(1, 200, "t5");
    checkOutput("t5_byte0", 32'(txLog[0]), 32'h5A);
    txModelOn  = 1'b0;
    manualBusy = 1'b1;
    repeat (3) @(negedge clk);
    manualBusy = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t5_pulse_gv", 32'(bus.out_grant_valid), 32'd0);
    checkOutput("t5_pulse_tx_en", 32'(bus.out_tx_en), 32'd0);
    checkOutput("t5_pulse_ngrant", 32'(grantLog.size()), 32'd1);

    $display("[TB] reset while in SEND");
    clearLogs();
    applyStimulus(1, 8'h77, 1'b0);
    applyStimulus(1, 8'h88, 1'b1);
    n = 0;
    while (!bus.out_tx_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6_in_send", 32'(bus.out_tx_en), 32'd1);
    checkOutput("t6_send_data", 32'(bus.out_tx_data), 32'h77);
    rst_n     = 1'b0;
    txModelOn = 1'b1;
    applyStimulus(0, 8'h99, 1'b1);
    @(negedge clk);
    checkOutput("t6_rst_tx_en", 32'(bus.out_tx_en), 32'd0);
    checkOutput("t6_rst_gv", 32'(bus.out_grant_valid), 32'd0);
    checkOutput("t6_rst_abort", 32'(bus.out_abort), 32'd0);
    checkOutput("t6_rst_data", 32'(bus.out_tx_data), 32'd0);
    rst_n = 1'b1;
    clearLogs();
    waitDone(2, 400, "t6");
    checkOutput("t6_grant0", 32'(grantLog[0]), 32'd0);
    checkOutput("t6_grant1", 32'(grantLog[1]), 32'd1);
    checkOutput("t6_byte0", 32'(txLog[0]), 32'h99);
    checkOutput("t6_byte1", 32'(txLog[1]), 32'h88);
    checkOutput("t6_abort_count", 32'(abortCount), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
